// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - operand fetch, RAW forwarding, load-use stall and ID/EX pipeline register
module id_ex_stage #(
  parameter logic [3:0] LOAD_OP = 4'hC,
  parameter logic [3:0] NOP_OP  = 4'h0,
  parameter int         CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       ID_Instr,
  input  logic             ID_Valid,
  input  logic             Flush,
  output logic [1:0]       R1_Adr,
  output logic [1:0]       R2_Adr,
  input  logic [7:0]       R1,
  input  logic [7:0]       R2,
  input  logic             EX_W_En,
  input  logic             EX_Is_Load,
  input  logic [1:0]       EX_W_Adr,
  input  logic [7:0]       EX_Result,
  input  logic             MEM_W_En,
  input  logic [1:0]       MEM_W_Adr,
  input  logic [7:0]       MEM_Data,
  input  logic             WB_W_En,
  input  logic [1:0]       WB_W_Adr,
  input  logic [7:0]       WB_Data,
  output logic             Stall,
  output logic             EX_Valid,
  output logic [3:0]       EX_Op,
  output logic [1:0]       EX_Ra,
  output logic [1:0]       EX_Rb,
  output logic [7:0]       EX_A,
  output logic [7:0]       EX_B,
  output logic [CNT_W-1:0] Stall_Cnt
);

  // A load opcode equal to the bubble opcode would make bubbles indistinguishable from loads.
  if (LOAD_OP == NOP_OP) begin : g_bad_opcodes
    $error("id_ex_stage: LOAD_OP must differ from NOP_OP");
  end

  logic [3:0] id_op;
  logic [1:0] id_ra;
  logic [1:0] id_rb;
  logic [7:0] opnd_a;
  logic [7:0] opnd_b;
  logic       hit_ra;
  logic       hit_rb;
  logic       cnt_full;

  assign id_op  = ID_Instr[7:4];
  assign id_ra  = ID_Instr[3:2];
  assign id_rb  = ID_Instr[1:0];
  assign R1_Adr = id_ra;
  assign R2_Adr = id_rb;

  // Youngest producer wins; a load in EX has no data yet, so it is skipped here and stalled on instead.
  function automatic logic [7:0] resolve(
    input logic [1:0] src,
    input logic [7:0] rf_data,
    input logic       ex_en,
    input logic       ex_load,
    input logic [1:0] ex_adr,
    input logic [7:0] ex_res,
    input logic       mem_en,
    input logic [1:0] mem_adr,
    input logic [7:0] mem_dat,
    input logic       wb_en,
    input logic [1:0] wb_adr,
    input logic [7:0] wb_dat
  );
    logic [7:0] val;
    val = rf_data;
    if (ex_en && (ex_adr == src) && !ex_load) begin
      val = ex_res;
    end else if (mem_en && (mem_adr == src)) begin
      val = mem_dat;
    end else if (wb_en && (wb_adr == src)) begin
      val = wb_dat;
    end
    return val;
  endfunction

  always_comb begin
    opnd_a = resolve(id_ra, R1, EX_W_En, EX_Is_Load, EX_W_Adr, EX_Result,
                     MEM_W_En, MEM_W_Adr, MEM_Data, WB_W_En, WB_W_Adr, WB_Data);
    opnd_b = resolve(id_rb, R2, EX_W_En, EX_Is_Load, EX_W_Adr, EX_Result,
                     MEM_W_En, MEM_W_Adr, MEM_Data, WB_W_En, WB_W_Adr, WB_Data);
  end

  // Both fields are treated as sources regardless of opcode; occasional false stalls are harmless.
  assign hit_ra   = (EX_W_Adr == id_ra);
  assign hit_rb   = (EX_W_Adr == id_rb);
  assign Stall    = ID_Valid & EX_W_En & EX_Is_Load & (hit_ra | hit_rb);
  assign cnt_full = &Stall_Cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EX_Valid  <= 1'b0;
      EX_Op     <= NOP_OP;
      EX_Ra     <= 2'd0;
      EX_Rb     <= 2'd0;
      EX_A      <= 8'd0;
      EX_B      <= 8'd0;
      Stall_Cnt <= '0;
    end else if (Flush) begin
      EX_Valid <= 1'b0;
      EX_Op    <= NOP_OP;
    end else if (Stall) begin
      EX_Valid <= 1'b0;
      EX_Op    <= NOP_OP;
      if (!cnt_full) begin
        Stall_Cnt <= Stall_Cnt + 1'b1;
      end
    end else begin
      EX_Valid <= ID_Valid;
      EX_Op    <= id_op;
      EX_Ra    <= id_ra;
      EX_Rb    <= id_rb;
      EX_A     <= opnd_a;
      EX_B     <= opnd_b;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  ID_Instr;
  logic        ID_Valid;
  logic        Flush;
  logic [1:0]  R1_Adr, R2_Adr;
  logic [7:0]  R1, R2;
  logic        EX_W_En, EX_Is_Load;
  logic [1:0]  EX_W_Adr;
  logic [7:0]  EX_Result;
  logic        MEM_W_En;
  logic [1:0]  MEM_W_Adr;
  logic [7:0]  MEM_Data;
  logic        WB_W_En;
  logic [1:0]  WB_W_Adr;
  logic [7:0]  WB_Data;
  logic        Stall;
  logic        EX_Valid;
  logic [3:0]  EX_Op;
  logic [1:0]  EX_Ra, EX_Rb;
  logic [7:0]  EX_A, EX_B;
  logic [15:0] Stall_Cnt;

  logic [7:0] rf [4];
  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  // Register file model with asynchronous read
  assign R1 = rf[R1_Adr];
  assign R2 = rf[R2_Adr];

  id_ex_stage dut (
    .CLK(CLK), .RST(RST), .ID_Instr(ID_Instr), .ID_Valid(ID_Valid), .Flush(Flush),
    .R1_Adr(R1_Adr), .R2_Adr(R2_Adr), .R1(R1), .R2(R2),
    .EX_W_En(EX_W_En), .EX_Is_Load(EX_Is_Load), .EX_W_Adr(EX_W_Adr), .EX_Result(EX_Result),
    .MEM_W_En(MEM_W_En), .MEM_W_Adr(MEM_W_Adr), .MEM_Data(MEM_Data),
    .WB_W_En(WB_W_En), .WB_W_Adr(WB_W_Adr), .WB_Data(WB_Data),
    .Stall(Stall), .EX_Valid(EX_Valid), .EX_Op(EX_Op), .EX_Ra(EX_Ra), .EX_Rb(EX_Rb),
    .EX_A(EX_A), .EX_B(EX_B), .Stall_Cnt(Stall_Cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rf[0] = 8'h00; rf[1] = 8'h11; rf[2] = 8'h22; rf[3] = 8'hFF;
    RST = 1'b1; ID_Instr = 8'h00; ID_Valid = 1'b0; Flush = 1'b0;
    EX_W_En = 1'b0; EX_Is_Load = 1'b0; EX_W_Adr = 2'd0; EX_Result = 8'h00;
    MEM_W_En = 1'b0; MEM_W_Adr = 2'd0; MEM_Data = 8'h00;
    WB_W_En = 1'b0; WB_W_Adr = 2'd0; WB_Data = 8'h00;

    #12;
    check("rst_valid", 16'(EX_Valid), 16'h0);
    check("rst_op", 16'(EX_Op), 16'h0);
    check("rst_a", 16'(EX_A), 16'h0);
    check("rst_b", 16'(EX_B), 16'h0);
    check("rst_cnt", Stall_Cnt, 16'h0000);
    check("rst_stall", 16'(Stall), 16'h0);
    RST = 1'b0;

    // No hazard: both fields name r1
    ID_Instr = 8'h25; ID_Valid = 1'b1;
    #1;
    check("r1_adr", 16'(R1_Adr), 16'h1);
    check("r2_adr", 16'(R2_Adr), 16'h1);
    step();
    check("nohaz_valid", 16'(EX_Valid), 16'h1);
    check("nohaz_op", 16'(EX_Op), 16'h2);
    check("nohaz_ra", 16'(EX_Ra), 16'h1);
    check("nohaz_rb", 16'(EX_Rb), 16'h1);
    check("nohaz_a", 16'(EX_A), 16'h11);
    check("nohaz_b", 16'(EX_B), 16'h11);

    // Forward priority on ra=2
    ID_Instr = 8'h38;
    EX_W_En = 1'b1; EX_W_Adr = 2'd2; EX_Result = 8'hAA;
    MEM_W_En = 1'b1; MEM_W_Adr = 2'd2; MEM_Data = 8'hBB;
    WB_W_En = 1'b1; WB_W_Adr = 2'd2; WB_Data = 8'hCC;
    step();
    check("fwd_ex", 16'(EX_A), 16'hAA);
    check("fwd_ex_b", 16'(EX_B), 16'h00);
    EX_W_En = 1'b0;
    step();
    check("fwd_mem", 16'(EX_A), 16'hBB);
    MEM_W_En = 1'b0;
    step();
    check("fwd_wb", 16'(EX_A), 16'hCC);
    WB_W_En = 1'b0;
    step();
    check("fwd_none", 16'(EX_A), 16'h22);

    // WB bypass over a stale register file value
    ID_Instr = 8'h13; WB_W_En = 1'b1; WB_W_Adr = 2'd3; WB_Data = 8'h7F;
    step();
    check("wb_byp_b", 16'(EX_B), 16'h7F);
    check("wb_byp_op", 16'(EX_Op), 16'h1);
    WB_W_En = 1'b0;

    // Load-use on rb=1
    ID_Instr = 8'h51; EX_W_En = 1'b1; EX_Is_Load = 1'b1; EX_W_Adr = 2'd1; EX_Result = 8'hEE;
    #1;
    check("lu_stall", 16'(Stall), 16'h1);
    step();
    check("lu_valid", 16'(EX_Valid), 16'h0);
    check("lu_op", 16'(EX_Op), 16'h0);
    check("lu_cnt", Stall_Cnt, 16'h0001);
    EX_W_En = 1'b0; EX_Is_Load = 1'b0;
    MEM_W_En = 1'b1; MEM_W_Adr = 2'd1; MEM_Data = 8'h5A;
    #1;
    check("lu_release", 16'(Stall), 16'h0);
    step();
    check("lu_b", 16'(EX_B), 16'h5A);
    check("lu_issue_valid", 16'(EX_Valid), 16'h1);
    check("lu_issue_op", 16'(EX_Op), 16'h5);
    check("lu_cnt_hold", Stall_Cnt, 16'h0001);
    MEM_W_En = 1'b0;

    // Flush wins over a concurrent stall
    EX_W_En = 1'b1; EX_Is_Load = 1'b1; EX_W_Adr = 2'd1; Flush = 1'b1;
    #1;
    check("fl_stall_comb", 16'(Stall), 16'h1);
    step();
    check("fl_valid", 16'(EX_Valid), 16'h0);
    check("fl_op", 16'(EX_Op), 16'h0);
    check("fl_cnt", Stall_Cnt, 16'h0001);
    Flush = 1'b0;

    // Empty ID slot never stalls
    ID_Valid = 1'b0;
    #1;
    check("idle_stall", 16'(Stall), 16'h0);
    step();
    check("idle_valid", 16'(EX_Valid), 16'h0);
    check("idle_cnt", Stall_Cnt, 16'h0001);

    // Drive the counter to saturation, then one more stall
    ID_Valid = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge CLK);
    #1;
    check("sat_reach", Stall_Cnt, 16'hFFFF);
    step();
    check("sat_hold", Stall_Cnt, 16'hFFFF);
    check("sat_valid", 16'(EX_Valid), 16'h0);

    // Async reset between edges
    EX_W_En = 1'b0; EX_Is_Load = 1'b0; ID_Instr = 8'h9B;
    step();
    check("pre_rst_valid", 16'(EX_Valid), 16'h1);
    check("pre_rst_op", 16'(EX_Op), 16'h9);
    check("pre_rst_a", 16'(EX_A), 16'h22);
    #2;
    RST = 1'b1;
    #1;
    check("arst_valid", 16'(EX_Valid), 16'h0);
    check("arst_op", 16'(EX_Op), 16'h0);
    check("arst_cnt", Stall_Cnt, 16'h0000);
    check("arst_a", 16'(EX_A), 16'h00);
    #1;
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Operand-fetch stage and ID/EX pipeline register of the 8-bit pipelined core.
- Drives the register file read addresses and captures the asynchronous read data.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and by a one-cycle load-use stall.
- Registers opcode, register indices and resolved operands for the EX stage, with stall, flush and a saturating stall counter.

Parameters:
- LOAD_OP, 4'hC, opcode whose result is available only after MEM (triggers load-use stall).
- NOP_OP, 4'h0, opcode loaded into EX_Op when a bubble is inserted.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- ID_Instr  in  8  instruction from IF/ID: [7:4] op, [3:2] ra (dest/src1), [1:0] rb (src2).
- ID_Valid  in  1  ID_Instr holds a real instruction.
- Flush  in  1  taken branch/jump resolved in EX; squash ID.
- R1_Adr  out  2  register file read port 1 address (= ID_Instr[3:2]).
- R2_Adr  out  2  register file read port 2 address (= ID_Instr[1:0]).
- R1  in  8  register file read data 1.
- R2  in  8  register file read data 2.
- EX_W_En, EX_Is_Load  in  1 each  instruction currently in EX writes a register / is a load.
- EX_W_Adr  in  2  EX destination.
- EX_Result  in  8  EX ALU result (combinational).
- MEM_W_En  in  1  MEM-stage write enable.
- MEM_W_Adr  in  2  MEM destination.
- MEM_Data  in  8  MEM write-back value (load data or ALU result).
- WB_W_En  in  1  same signals as register file W_En.
- WB_W_Adr  in  2  same signals as register file W_Adr.
- WB_Data  in  8  same signals as register file Data_in.
- Stall  out  1  hold PC and IF/ID this cycle.
- EX_Valid  out  1  EX registers hold a real instruction.
- EX_Op  out  4  registered opcode.
- EX_Ra, EX_Rb  out  2 each  registered register indices.
- EX_A, EX_B  out  8 each  registered resolved operands.
- Stall_Cnt  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Reset (asynchronous, immediate):
  - EX_Valid=0, EX_Op=NOP_OP, EX_Ra=EX_Rb=0, EX_A=EX_B=0, Stall_Cnt=0.
  - Stall is combinational, so it is 0 while ID_Valid=0.
- R1_Adr/R2_Adr are combinational from ID_Instr regardless of ID_Valid.
- Operand resolution is combinational and evaluated independently for src1 (ra) and src2 (rb). First match wins:
  1. EX_W_En and EX_W_Adr==src and !EX_Is_Load → EX_Result.
  2. MEM_W_En and MEM_W_Adr==src → MEM_Data.
  3. WB_W_En and WB_W_Adr==src → WB_Data. This covers the same-cycle write, because the register file updates only at the edge.
  4. Otherwise R1 / R2.
- Load-use hazard: Stall = ID_Valid & EX_W_En & EX_Is_Load & (EX_W_Adr==ra | EX_W_Adr==rb).
  - Both sources are always treated as read. False stalls are accepted.
- Register update at posedge CLK, in priority order:
  1. Flush=1: EX_Valid<=0, EX_Op<=NOP_OP. Stall is ignored and the counter does not increment.
  2. Else Stall=1: bubble, so EX_Valid<=0 and EX_Op<=NOP_OP. Stall_Cnt increments, saturating at all-ones (no wrap).
  3. Else: EX_Valid<=ID_Valid, EX_Op<=op, EX_Ra<=ra, EX_Rb<=rb, EX_A/EX_B<=resolved operands.
- When a bubble is inserted, EX_Ra/EX_Rb/EX_A/EX_B may be left unchanged. The EX stage qualifies everything with EX_Valid.
- ID_Valid=0 with no flush propagates EX_Valid=0 without stalling.
- Latency: one cycle ID→EX. A load-dependent instruction issues exactly one cycle late and then takes its operand from MEM_Data.
- Stall never lasts more than one consecutive cycle: in the next cycle the load is in MEM and the EX slot holds a bubble.
- RST asserted mid-stall clears the stall state immediately. The instruction in ID is re-presented after reset by the fetch logic.

Test Plan:
- No hazard: R1=8'h11, R2=8'h22, ID_Instr=8'h25, no W_En asserted → next edge EX_Op=2, EX_Ra=1, EX_Rb=1, EX_A=EX_B=8'h11 (R1 and R2 both follow R1_Adr=R2_Adr=1), EX_Valid=1.
- Forward priority: ra=2, EX_W_En with EX_W_Adr=2 and EX_Result=8'hAA, MEM_Data=8'hBB to r2, WB_Data=8'hCC to r2 → EX_A=8'hAA.
  - Drop EX_W_En → 8'hBB.
  - Drop MEM_W_En → 8'hCC.
- WB bypass: WB_W_En=1, WB_W_Adr=3, WB_Data=8'h7F, R2=8'hFF stale, rb=3 → EX_B=8'h7F.
- Load-use: EX_Is_Load=1 with dest 1, ID rb=1 → Stall=1 for one cycle, EX_Valid=0, Stall_Cnt 0→1.
  - Next cycle MEM_W_Adr=1 and MEM_Data=8'h5A → Stall=0, EX_B=8'h5A.
- Flush over stall: Flush=1 while Stall=1 → EX_Valid=0, Stall_Cnt unchanged.
  - Preload Stall_Cnt to 16'hFFFF then force one more stall → stays 16'hFFFF.
- Async reset: RST pulse between edges while EX_Valid=1 → EX_Valid=0 and EX_Op=NOP_OP immediately, without waiting for a CLK edge.
